// File: rtl/rom_access_arbiter_if.sv
// Fetch and debug read-request bundle for the shared instruction ROM port.
// master = requester side, slave = arbiter side.
interface rom_access_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    modport master (
        output f_req, f_addr, d_req, d_addr,
        input  f_ack, f_rdata, f_err, d_ack, d_rdata, d_err
    );

    modport slave (
        input  f_req, f_addr, d_req, d_addr,
        output f_ack, f_rdata, f_err, d_ack, d_rdata, d_err
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing the combinational rom32 read port between
// the fetch and debug requesters; registered address, data and ack pulse.
module rom_access_arbiter #(
    parameter logic [24:0] BASE_ADDRESS = 25'd0,
    parameter int          CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    rom_access_arbiter_if.slave  bus,
    output logic [31:0]          rom_addr,
    input  logic [31:0]          rom_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     n_reads,
    output logic [CNT_W-1:0]     n_errs
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_ACK
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        r_last_dbg;
    logic        r_win_dbg;
    logic        r_err_pend;
    logic [31:0] r_rom_addr;
    logic        r_f_ack;
    logic        r_d_ack;
    logic        r_f_err;
    logic        r_d_err;
    logic [31:0] r_f_rdata;
    logic [31:0] r_d_rdata;
    logic [CNT_W-1:0] r_n_reads;
    logic [CNT_W-1:0] r_n_errs;

    logic        w_any;
    logic        w_pick_dbg;
    logic [31:0] w_sel_addr;
    logic        w_addr_err;
    logic [31:0] w_rdata;
    logic        w_grant;
    logic        w_load;
    logic        w_done;

    // On a tie the port that did not win last time is served
    assign w_any      = bus.f_req | bus.d_req;
    assign w_pick_dbg = bus.d_req & (~bus.f_req | ~r_last_dbg);
    assign w_sel_addr = w_pick_dbg ? bus.d_addr : bus.f_addr;
    assign w_addr_err = (w_sel_addr[1:0] != 2'b00)
                      | (w_sel_addr[31:7] != BASE_ADDRESS);
    assign w_rdata    = r_err_pend ? 32'h0 : rom_data;

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_load  = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next  = S_READ;
                    w_grant = 1'b1;
                end
            end
            S_READ: begin
                w_next = S_ACK;
                w_load = 1'b1;
            end
            S_ACK: begin
                w_next = S_IDLE;
                w_done = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rom_addr <= 32'h0;
            r_last_dbg <= 1'b1;
            r_win_dbg  <= 1'b0;
            r_err_pend <= 1'b0;
        end else if (w_grant) begin
            r_rom_addr <= w_sel_addr;
            r_last_dbg <= w_pick_dbg;
            r_win_dbg  <= w_pick_dbg;
            r_err_pend <= w_addr_err;
        end
    end

    // Acks are single-cycle; data and err persist until the port's next ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_f_err   <= 1'b0;
            r_d_err   <= 1'b0;
            r_f_rdata <= 32'h0;
            r_d_rdata <= 32'h0;
        end else begin
            r_f_ack <= w_load & ~r_win_dbg;
            r_d_ack <= w_load & r_win_dbg;
            if (w_load && !r_win_dbg) begin
                r_f_rdata <= w_rdata;
                r_f_err   <= r_err_pend;
            end
            if (w_load && r_win_dbg) begin
                r_d_rdata <= w_rdata;
                r_d_err   <= r_err_pend;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n_reads <= '0;
            r_n_errs  <= '0;
        end else if (w_done) begin
            if (r_n_reads != '1) begin
                r_n_reads <= r_n_reads + 1'b1;
            end
            if (r_err_pend && (r_n_errs != '1)) begin
                r_n_errs <= r_n_errs + 1'b1;
            end
        end
    end

    assign rom_addr    = r_rom_addr;
    assign busy        = (r_state != S_IDLE);
    assign n_reads     = r_n_reads;
    assign n_errs      = r_n_errs;
    assign bus.f_ack   = r_f_ack;
    assign bus.f_rdata = r_f_rdata;
    assign bus.f_err   = r_f_err;
    assign bus.d_ack   = r_d_ack;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_err   = r_d_err;

endmodule
